store_rmw_ctrl: RTL

STORE_RMW_CTRL -- requirements
Module: store_rmw_ctrl

---
 rtl/store_rmw_ctrl_pkg.sv | 32 +++
 rtl/store_merge.sv | 38 +++
 rtl/store_rmw_ctrl.sv | 138 +++++++++++++
 3 files changed

// File: rtl/store_rmw_ctrl_pkg.sv
// Shared encodings for the store read-modify-write controller:
// access sizes, FSM states, default read latency and the alignment check.
package store_rmw_ctrl_pkg;

   localparam logic [1:0] SZ_ILLEGAL = 2'b00;
   localparam logic [1:0] SZ_BYTE    = 2'b01;
   localparam logic [1:0] SZ_HALF    = 2'b10;
   localparam logic [1:0] SZ_WORD    = 2'b11;

   localparam int WAIT_CYCLES_DEF = 2;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_READ  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERR   = 3'd4
   } state_e;

   // Size must be encoded and the address naturally aligned for that size.
   function automatic logic access_legal(input logic [1:0] size, input logic [1:0] lane);
      logic ok;
      case (size)
         SZ_BYTE: ok = 1'b1;
         SZ_HALF: ok = ~lane[0];
         SZ_WORD: ok = (lane == 2'b00);
         default: ok = 1'b0;
      endcase
      return ok;
   endfunction

endpackage

// File: rtl/store_merge.sv
// Combinational lane merge: overlays the store data onto the word read
// from memory, little-endian lane numbering.
module store_merge
   import store_rmw_ctrl_pkg::*;
(
   input  logic [31:0] mdr,
   input  logic [31:0] data,
   input  logic [1:0]  size,
   input  logic [1:0]  lane,
   output logic [31:0] merged
);

   // Replace only the addressed byte/half; untouched bits keep the memory value.
   always_comb begin
      merged = mdr;
      case (size)
         SZ_BYTE: begin
            case (lane)
               2'd0:    merged[7:0]   = data[7:0];
               2'd1:    merged[15:8]  = data[7:0];
               2'd2:    merged[23:16] = data[7:0];
               2'd3:    merged[31:24] = data[7:0];
               default: merged        = mdr;
            endcase
         end
         SZ_HALF: begin
            if (lane[1]) begin
               merged[31:16] = data[15:0];
            end else begin
               merged[15:0] = data[15:0];
            end
         end
         SZ_WORD: merged = data;
         default: merged = mdr;
      endcase
   end

endmodule

// File: rtl/store_rmw_ctrl.sv
// Store controller: sub-word stores become read-modify-write sequences,
// aligned word stores write directly, misaligned/illegal requests pulse err.
module store_rmw_ctrl
   import store_rmw_ctrl_pkg::*;
#(
   parameter int WAIT_CYCLES = WAIT_CYCLES_DEF
)
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_data,
   input  logic [1:0]  req_size,
   output logic [31:0] mem_addr,
   output logic        mem_rd,
   output logic        mem_wr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        done,
   output logic        err
);

   localparam logic [3:0] LAST_CNT = 4'(WAIT_CYCLES - 1);

   state_e      state_r, state_d;
   logic [3:0]  cnt_r, cnt_d;
   logic [31:0] addr_r, data_r, mdr_r, mdr_d, wdata_r, wdata_d, merged_s;
   logic [1:0]  size_r, lane_r;
   logic        accept_s, capture_s;
   logic        ready_r, rd_r, wr_r, done_r, err_r;

   assign accept_s = (state_r == ST_IDLE) && req_valid;

   // Next-state, read-wait counter and MDR capture strobe.
   always_comb begin
      state_d   = state_r;
      cnt_d     = 4'd0;
      capture_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (req_valid) begin
               if (!access_legal(req_size, req_addr[1:0])) begin
                  state_d = ST_ERR;
               end else if (req_size == SZ_WORD) begin
                  state_d = ST_WRITE;
               end else begin
                  state_d = ST_READ;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_READ: begin
            if (cnt_r == LAST_CNT) begin
               state_d   = ST_WRITE;
               capture_s = 1'b1;
            end else begin
               cnt_d = cnt_r + 4'd1;
            end
         end
         ST_WRITE: state_d = ST_DONE;
         ST_DONE:  state_d = ST_IDLE;
         ST_ERR:   state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // The merge sees the word being captured this edge so the write data is
   // ready to register together with the MDR.
   always_comb begin
      if (capture_s) begin
         mdr_d = mem_rdata;
      end else begin
         mdr_d = mdr_r;
      end
      if (accept_s && (state_d == ST_WRITE)) begin
         wdata_d = req_data;
      end else if (capture_s) begin
         wdata_d = merged_s;
      end else begin
         wdata_d = wdata_r;
      end
   end

   store_merge u_merge (
      .mdr    (mdr_d),
      .data   (data_r),
      .size   (size_r),
      .lane   (lane_r),
      .merged (merged_s)
   );

   // State, request latches and registered output strobes decoded from next state.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 4'd0;
         addr_r  <= 32'd0;
         data_r  <= 32'd0;
         size_r  <= 2'b00;
         lane_r  <= 2'b00;
         mdr_r   <= 32'd0;
         wdata_r <= 32'd0;
         ready_r <= 1'b1;
         rd_r    <= 1'b0;
         wr_r    <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state_r <= state_d;
         cnt_r   <= cnt_d;
         mdr_r   <= mdr_d;
         wdata_r <= wdata_d;
         if (accept_s) begin
            addr_r <= {req_addr[31:2], 2'b00};
            data_r <= req_data;
            size_r <= req_size;
            lane_r <= req_addr[1:0];
         end
         ready_r <= (state_d == ST_IDLE);
         rd_r    <= (state_d == ST_READ);
         wr_r    <= (state_d == ST_WRITE);
         done_r  <= (state_d == ST_DONE);
         err_r   <= (state_d == ST_ERR);
      end
   end

   assign req_ready = ready_r;
   assign mem_addr  = addr_r;
   assign mem_rd    = rd_r;
   assign mem_wr    = wr_r;
   assign mem_wdata = wdata_r;
   assign done      = done_r;
   assign err       = err_r;

endmodule
